// File: rtl/mac_pkg.sv
// Shared defaults, pointer sizing and FSM states for the MAC stream controller.
package mac_pkg;

   localparam int DEF_DATA_W  = 4;
   localparam int DEF_VEC_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_PTR_W = ptr_w(DEF_VEC_LEN);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      STREAM  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/mac_stream_ctrl_if.sv
// Operand stream, MAC drive and result handshake bundle; slave is the controller's view.
interface mac_stream_ctrl_if
   import mac_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_ifmap;
   logic [DATA_W-1:0] in_weight;
   logic [DATA_W-1:0] mac_ifmap;
   logic [DATA_W-1:0] mac_weights;
   logic              mac_en;
   logic              mac_lastdata;
   logic [DATA_W-1:0] mac_accumulation;
   logic              result_valid;
   logic              result_ready;
   logic [DATA_W-1:0] result;
   logic [CNT_W-1:0]  vec_count;

   modport slave (
      input  in_valid, in_ifmap, in_weight, mac_accumulation, result_ready,
      output in_ready, mac_ifmap, mac_weights, mac_en, mac_lastdata,
             result_valid, result, vec_count
   );

   modport master (
      output in_valid, in_ifmap, in_weight, mac_accumulation, result_ready,
      input  in_ready, mac_ifmap, mac_weights, mac_en, mac_lastdata,
             result_valid, result, vec_count
   );
endinterface

// File: rtl/mac_operand_buf.sv
// Operand-pair register file: synchronous write, combinational read, storage not reset.
module mac_operand_buf
   import mac_pkg::*;
#(
   parameter int DEPTH = DEF_VEC_LEN,
   parameter int WIDTH = 2 * DEF_DATA_W,
   parameter int AW    = DEF_PTR_W
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/mac_stream_ctrl.sv
// Buffers VEC_LEN operand pairs, replays them into the MAC, then holds the sum until taken.
// result_valid rises VEC_LEN+1 edges after the last accept; operand input is closed until handoff.
module mac_stream_ctrl
   import mac_pkg::*;
#(
   parameter int VEC_LEN = DEF_VEC_LEN,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input logic              clk,
   input logic              reset,
   mac_stream_ctrl_if.slave bus
);
   localparam int               PTR_W       = ptr_w(VEC_LEN);
   localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(VEC_LEN - 1);
   localparam logic [PTR_W-1:0] PRELAST_IDX = PTR_W'(VEC_LEN - 2);

   state_t              state;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic                mac_en_q;
   logic                mac_last_q;
   logic                result_valid_q;
   logic [DATA_W-1:0]   result_q;
   logic [CNT_W-1:0]    vec_count_q;
   logic [2*DATA_W-1:0] rd_pair;
   logic                accept;

   assign accept = (state == FILL) && bus.in_valid;

   mac_operand_buf #(
      .DEPTH (VEC_LEN),
      .WIDTH (2 * DATA_W),
      .AW    (PTR_W)
   ) u_buf (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata ({bus.in_ifmap, bus.in_weight}),
      .raddr (rd_ptr),
      .rdata (rd_pair)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= FILL;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         mac_en_q       <= 1'b0;
         mac_last_q     <= 1'b0;
         result_valid_q <= 1'b0;
         result_q       <= '0;
         vec_count_q    <= '0;
      end else begin
         case (state)
            FILL: begin
               if (bus.in_valid) begin
                  if (wr_ptr == LAST_IDX) begin
                     wr_ptr     <= '0;
                     rd_ptr     <= '0;
                     mac_en_q   <= 1'b1;
                     mac_last_q <= 1'b0;
                     state      <= STREAM;
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            STREAM: begin
               // en/lastdata are registered one step ahead of rd_ptr so they line up with the read
               rd_ptr     <= rd_ptr + 1'b1;
               mac_last_q <= (rd_ptr == PRELAST_IDX);
               if (rd_ptr == LAST_IDX) begin
                  rd_ptr     <= '0;
                  mac_en_q   <= 1'b0;
                  mac_last_q <= 1'b0;
                  state      <= CAPTURE;
               end
            end
            CAPTURE: begin
               result_q       <= bus.mac_accumulation;
               result_valid_q <= 1'b1;
               state          <= HOLD;
            end
            HOLD: begin
               if (bus.result_ready) begin
                  result_valid_q <= 1'b0;
                  vec_count_q    <= vec_count_q + 1'b1;
                  state          <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign bus.in_ready     = (state == FILL);
   assign bus.mac_en       = mac_en_q;
   assign bus.mac_lastdata = mac_last_q;
   assign bus.mac_ifmap    = mac_en_q ? rd_pair[2*DATA_W-1:DATA_W] : '0;
   assign bus.mac_weights  = mac_en_q ? rd_pair[DATA_W-1:0] : '0;
   assign bus.result_valid = result_valid_q;
   assign bus.result       = result_q;
   assign bus.vec_count    = vec_count_q;
endmodule
